// File: rtl/led_matrix_scheduler.sv
// Two-source 8x8 LED matrix scheduler: per-requester pending slots, round-robin with minimum hold,
// frame-aligned display swap and row/column scan. Optional macro LED_SCHED_BLANK_EN blanks each row's start.
module led_matrix_scheduler #(
    parameter int unsigned SCAN_DIV    = 65536,
    parameter int unsigned HOLD_FRAMES = 4
) (
    input  logic        i_CLK,
    input  logic        i_RSTn,
    input  logic        i_REQ0_DV,
    input  logic [63:0] i_REQ0_DATA,
    output logic        o_REQ0_ACK,
    input  logic        i_REQ1_DV,
    input  logic [63:0] i_REQ1_DATA,
    output logic        o_REQ1_ACK,
    output logic [7:0]  o_ROWS,
    output logic [7:0]  o_COLS,
    output logic        o_OWNER,
    output logic        o_FRAME_TICK
);

    localparam int unsigned    PRE_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] BLANK_LEN = PRE_W'(SCAN_DIV >> 3);
    localparam logic [7:0]     HOLD_MIN  = 8'(HOLD_FRAMES);
`ifdef LED_SCHED_BLANK_EN
    localparam logic           BLANK_EN  = 1'b1;
`else
    localparam logic           BLANK_EN  = 1'b0;
`endif

    typedef enum logic {ST_IDLE, ST_SCAN} state_e;

    state_e             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [2:0]         row_q, row_d;
    logic [1:0]         full_q, full_d;
    logic [63:0]        slot0_q, slot0_d, slot1_q, slot1_d;
    logic [63:0]        disp_q, disp_d;
    logic               owner_q, owner_d;
    logic [7:0]         hold_q, hold_d;
    logic [1:0]         ack_q, ack_d;
    logic               tick_q, tick_d;
    logic [7:0]         rows_q, rows_d, cols_q, cols_d;

    logic               row_end, frame_end, other, show;
    logic [7:0]         hold_inc;

    // Next-state: scan counters, frame-boundary arbitration, slot capture, registered outputs
    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        row_d    = row_q;
        full_d   = full_q;
        slot0_d  = slot0_q;
        slot1_d  = slot1_q;
        disp_d   = disp_q;
        owner_d  = owner_q;
        hold_d   = hold_q;
        ack_d    = 2'b00;
        tick_d   = 1'b0;
        rows_d   = 8'h00;
        cols_d   = 8'hFF;
        show     = 1'b0;

        row_end   = (pre_q == PRE_LAST);
        frame_end = row_end && (row_q == 3'd7);
        other     = ~owner_q;
        hold_inc  = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;

        if (row_end) begin
            pre_d = '0;
            row_d = row_q + 3'd1;
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end

        if (frame_end) begin
            tick_d = 1'b1;
            if (state_q == ST_IDLE) begin
                if (full_q[0]) begin
                    disp_d    = slot0_q;
                    owner_d   = 1'b0;
                    full_d[0] = 1'b0;
                    hold_d    = 8'd0;
                    state_d   = ST_SCAN;
                end else if (full_q[1]) begin
                    disp_d    = slot1_q;
                    owner_d   = 1'b1;
                    full_d[1] = 1'b0;
                    hold_d    = 8'd0;
                    state_d   = ST_SCAN;
                end
            end else if (full_q[other] && (!full_q[owner_q] || hold_inc >= HOLD_MIN)) begin
                disp_d        = other ? slot1_q : slot0_q;
                owner_d       = other;
                full_d[other] = 1'b0;
                hold_d        = 8'd0;
            end else begin
                hold_d = hold_inc;
                if (full_q[owner_q]) begin
                    disp_d          = owner_q ? slot1_q : slot0_q;
                    full_d[owner_q] = 1'b0;
                end
            end
        end

        // A slot emptied on the boundary cycle is still full here, so its ack waits one cycle
        if (i_REQ0_DV && !full_q[0]) begin
            slot0_d   = i_REQ0_DATA;
            full_d[0] = 1'b1;
            ack_d[0]  = 1'b1;
        end
        if (i_REQ1_DV && !full_q[1]) begin
            slot1_d   = i_REQ1_DATA;
            full_d[1] = 1'b1;
            ack_d[1]  = 1'b1;
        end

        show = (state_d == ST_SCAN);
        if (BLANK_EN && (pre_d < BLANK_LEN)) begin
            show = 1'b0;
        end
        if (show) begin
            rows_d = 8'd1 << row_d;
            cols_d = ~disp_d[{row_d, 3'b000} +: 8];
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            row_q   <= 3'd0;
            full_q  <= 2'b00;
            slot0_q <= 64'd0;
            slot1_q <= 64'd0;
            disp_q  <= 64'd0;
            owner_q <= 1'b0;
            hold_q  <= 8'd0;
            ack_q   <= 2'b00;
            tick_q  <= 1'b0;
            rows_q  <= 8'h00;
            cols_q  <= 8'hFF;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            row_q   <= row_d;
            full_q  <= full_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            disp_q  <= disp_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            ack_q   <= ack_d;
            tick_q  <= tick_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
        end
    end

    assign o_REQ0_ACK   = ack_q[0];
    assign o_REQ1_ACK   = ack_q[1];
    assign o_ROWS       = rows_q;
    assign o_COLS       = cols_q;
    assign o_OWNER      = owner_q;
    assign o_FRAME_TICK = tick_q;

endmodule

// File: tb/tb_led_matrix_scheduler.sv
// Directed bench for led_matrix_scheduler: expected displayed frames are queued as frames are handed over
// and checked row by row after each frame tick.
module tb_led_matrix_scheduler;

    localparam int unsigned SCAN_DIV    = 8;
    localparam int unsigned HOLD_FRAMES = 2;
`ifdef LED_SCHED_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    localparam logic [63:0] F0A = 64'h8040_2010_0804_0201;
    localparam logic [63:0] F0B = 64'h0102_0408_1020_4080;
    localparam logic [63:0] F1  = 64'hFF00_0000_0000_0000;
    localparam logic [63:0] F0C = 64'h0F0F_0F0F_F0F0_F0F0;
    localparam logic [63:0] F1B = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] F1C = 64'hAA55_AA55_AA55_AA55;
    localparam logic [63:0] D0  = 64'h0000_0000_0000_003C;
    localparam logic [63:0] D1  = 64'h3C00_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dv0, dv1, ack0, ack1, owner, tick;
    logic [63:0] d0, d1;
    logic [7:0]  rows, cols;

    typedef struct {
        logic [63:0] data;
        logic        owner;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;
    int   pos   = 0;
    int   acks;
    int   viol;

    always #5 clk = ~clk;

    led_matrix_scheduler #(.SCAN_DIV(SCAN_DIV), .HOLD_FRAMES(HOLD_FRAMES)) dut (
        .i_CLK(clk), .i_RSTn(rst_n),
        .i_REQ0_DV(dv0), .i_REQ0_DATA(d0), .o_REQ0_ACK(ack0),
        .i_REQ1_DV(dv1), .i_REQ1_DATA(d1), .o_REQ1_ACK(ack1),
        .o_ROWS(rows), .o_COLS(cols), .o_OWNER(owner), .o_FRAME_TICK(tick)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance to the next falling edge; pos is the cycle index within the current frame
    task automatic step();
        @(negedge clk);
        if (tick === 1'b1) pos = 0;
        else pos++;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0; dv0 = 1'b0; dv1 = 1'b0;
        repeat (3) step();
        chk({tag, "_rows"}, rows, 8'h00);
        chk({tag, "_cols"}, cols, 8'hFF);
        chk({tag, "_ack0"}, ack0, 0);
        chk({tag, "_ack1"}, ack1, 0);
        chk({tag, "_owner"}, owner, 0);
        chk({tag, "_tick"}, tick, 0);
        rst_n = 1'b1;
    endtask

    task automatic wait_tick(output int n_acks);
        logic seen = 1'b0;
        n_acks = 0;
        for (int g = 0; g < 200 && !seen; g++) begin
            step();
            n_acks += int'(ack0) + int'(ack1);
            if (tick === 1'b1) seen = 1'b1;
        end
        chk("tick_seen", seen, 1);
    endtask

    task automatic present(input bit k, input logic [63:0] data, input string tag);
        if (k) begin dv1 = 1'b1; d1 = data; end
        else   begin dv0 = 1'b1; d0 = data; end
        step();
        chk({tag, "_ack"}, k ? ack1 : ack0, 1);
        dv0 = 1'b0; dv1 = 1'b0;
        step();
        chk({tag, "_ack_pulse"}, k ? ack1 : ack0, 0);
    endtask

    task automatic present_both(input logic [63:0] a, input logic [63:0] b, input string tag);
        dv0 = 1'b1; d0 = a; dv1 = 1'b1; d1 = b;
        step();
        chk({tag, "_ack0"}, ack0, 1);
        chk({tag, "_ack1"}, ack1, 1);
        dv0 = 1'b0; dv1 = 1'b0;
        step();
        chk({tag, "_acks_low"}, {ack0, ack1}, 0);
    endtask

    task automatic push_exp(input logic [63:0] data, input logic own);
        exp_t e;
        e.data  = data;
        e.owner = own;
        sbq.push_back(e);
    endtask

    task automatic pop_exp();
        chk("sb_has_entry", sbq.size() != 0, 1);
        if (sbq.size() != 0) cur = sbq.pop_front();
    endtask

    // Walk the rest of the current frame, checking mid-row samples against the expected frame
    task automatic check_frame(input string tag, output int n_acks);
        int zeros = 0;
        int expz  = 0;
        int r;
        logic [7:0] exp_cols;
        n_acks = 0;
        for (int g = 0; g < 80; g++) begin
            if (rows == 8'h00) zeros++;
            if (BLANK && (pos % 8 == 0)) expz++;
            n_acks += int'(ack0) + int'(ack1);
            if (pos % 8 == 4) begin
                r = pos / 8;
                exp_cols = ~cur.data[r*8 +: 8];
                chk($sformatf("%s_row%0d_rows", tag, r), rows, 8'd1 << r);
                chk($sformatf("%s_row%0d_cols", tag, r), cols, exp_cols);
                chk($sformatf("%s_row%0d_owner", tag, r), owner, cur.owner);
            end
            if (pos == 63) break;
            step();
        end
        chk({tag, "_dark_rows"}, zeros, expz);
    endtask

    initial begin
        rst_n = 1'b0; dv0 = 1'b0; dv1 = 1'b0; d0 = '0; d1 = '0;

        do_reset("rst0");
        viol = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (rows !== 8'h00 || cols !== 8'hFF || ack0 !== 1'b0 || ack1 !== 1'b0) viol++;
        end
        chk("idle_dark", viol, 0);
        wait_tick(acks);

        present(1'b0, 64'h0000_0000_0000_00A5, "load_a5");
        push_exp(64'h0000_0000_0000_00A5, 1'b0);
        wait_tick(acks);
        pop_exp();
        check_frame("single", acks);

        do_reset("rst1");
        wait_tick(acks);
        present(1'b0, F0A, "f0a");
        push_exp(F0A, 1'b0);
        wait_tick(acks);
        pop_exp();
        present_both(F0B, F1, "both_scan");
        push_exp(F0B, 1'b0);
        check_frame("t0", acks);
        wait_tick(acks);
        pop_exp();
        present(1'b0, F0C, "f0c");
        push_exp(F1, 1'b1);
        check_frame("t1", acks);
        wait_tick(acks);
        pop_exp();

        present(1'b1, F1B, "f1b");
        dv1 = 1'b1; d1 = F1C;
        push_exp(F1B, 1'b1);
        check_frame("t2", acks);
        chk("busy_no_ack_while_full", acks, 0);
        wait_tick(acks);
        chk("busy_no_ack_at_tick", acks, 0);
        step();
        chk("busy_ack_after_tick", ack1, 1);
        dv1 = 1'b0;
        step();
        chk("busy_ack_pulse", ack1, 0);
        pop_exp();
        push_exp(F0C, 1'b0);
        check_frame("t3", acks);
        wait_tick(acks);
        pop_exp();
        push_exp(F1C, 1'b1);
        check_frame("t4", acks);
        wait_tick(acks);
        pop_exp();
        check_frame("t5", acks);

        do_reset("rst2");
        wait_tick(acks);
        present_both(D0, D1, "both_idle");
        push_exp(D0, 1'b0);
        push_exp(D1, 1'b1);
        wait_tick(acks);
        pop_exp();
        check_frame("e0", acks);
        wait_tick(acks);
        pop_exp();
        check_frame("e1", acks);
        chk("sb_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
